// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control unit and ImmExt:
// opcodes, FSM states and every datapath select/control code.
package control_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_LUI
   } state_t;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Immediate format selected purely from the opcode; unknown opcodes fall back to I.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      logic [2:0] imm;
      case (op)
         OP_SW:   imm = IMM_S;
         OP_BEQ:  imm = IMM_B;
         OP_LUI:  imm = IMM_U;
         OP_JAL:  imm = IMM_J;
         default: imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus funct fields to the ALU operation code.
module alu_decoder
   import control_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only means sub for register-register ops; addi ignores it
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing each RV32I instruction through the multicycle datapath,
// with memory-ready stalls on fetch, load and store.
module multicycle_control
   import control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  imm_src,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_control,
   output logic        illegal_instr
);

   state_t     state_reg;
   state_t     state_next;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic       illegal_s;
   logic       unused_bits;

   assign op          = instruction[6:0];
   assign funct3      = instruction[14:12];
   assign funct7b5    = instruction[30];
   assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

   assign imm_src = imm_src_of(op);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= S_FETCH;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      pc_update   = 1'b0;
      branch      = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      illegal_s   = 1'b0;

      case (state_reg)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write_s = mem_ready;
            pc_update  = mem_ready;
            if (mem_ready)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            // ALUOut captures OldPC + imm so BEQ can redirect the PC from it
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               OP_LUI:       state_next = S_LUI;
               default: begin
                  state_next = S_FETCH;
                  illegal_s  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready)
               state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = RES_DATA;
            reg_write_s = 1'b1;
            state_next  = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            if (mem_ready)
               state_next = S_FETCH;
         end
         S_EXECUTER: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            state_next  = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            // PC <- ALUOut (branch target from DECODE); ALU forms OldPC + 4 for rd
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_update  = 1'b1;
            state_next = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a  = SRCA_ZERO;
            alu_src_b  = SRCB_IMM;
            state_next = S_ALUWB;
         end
         default: state_next = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

   // Reset gates every enable so no write escapes between the reset edge and FETCH.
   assign pc_write      = ~reset & (pc_update | (branch & zero));
   assign mem_write     = ~reset & mem_write_s;
   assign ir_write      = ~reset & ir_write_s;
   assign reg_write     = ~reset & reg_write_s;
   assign illegal_instr = ~reset & illegal_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of per-cycle vectors plus
// hand-written store-stall and reset-during-store sequences.
module tb_multicycle_control;

   typedef struct packed {
      logic [2:0] imm;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] alu;
      logic       ill;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        z;
      logic        mr;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = 32'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic [2:0]  imm_src;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [2:0]  alu_control;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   localparam logic [31:0] I_LW   = 32'hFFC4A303;
   localparam logic [31:0] I_SW   = 32'h0064A423;
   localparam logic [31:0] I_BEQ  = 32'hFE420AE3;
   localparam logic [31:0] I_JAL  = 32'h7F8A60EF;
   localparam logic [31:0] I_ADD  = 32'h00628233;
   localparam logic [31:0] I_SUB  = 32'h40628233;
   localparam logic [31:0] I_SLT  = 32'h0062A233;
   localparam logic [31:0] I_OR   = 32'h0062E233;
   localparam logic [31:0] I_ADDI = 32'hFFF00013;
   localparam logic [31:0] I_ANDI = 32'h0FF2F213;
   localparam logic [31:0] I_LUI  = 32'h123452B7;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   multicycle_control dut (
      .clk           (clk),
      .reset         (reset),
      .instruction   (instruction),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .imm_src       (imm_src),
      .pc_write      (pc_write),
      .adr_src       (adr_src),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_control   (alu_control),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   function automatic exp_t ex(logic [2:0] imm, logic pcw, logic adr, logic mw, logic irw,
                               logic rw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                               logic [2:0] alu, logic ill);
      return '{imm: imm, pcw: pcw, adr: adr, mw: mw, irw: irw, rw: rw,
               rs: rs, sa: sa, sb: sb, alu: alu, ill: ill};
   endfunction

   // Expected outputs per state, written straight from the state table.
   function automatic exp_t s_f(logic [2:0] i, logic mr);  return ex(i, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0); endfunction
   function automatic exp_t s_d(logic [2:0] i, logic il);  return ex(i, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, il); endfunction
   function automatic exp_t s_ma(logic [2:0] i);           return ex(i, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0); endfunction
   function automatic exp_t s_mr(logic [2:0] i);           return ex(i, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic exp_t s_mwb(logic [2:0] i);          return ex(i, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic exp_t s_mw(logic [2:0] i);           return ex(i, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic exp_t s_er(logic [2:0] i, logic [2:0] a); return ex(i, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, a, 0); endfunction
   function automatic exp_t s_ei(logic [2:0] i, logic [2:0] a); return ex(i, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, a, 0); endfunction
   function automatic exp_t s_awb(logic [2:0] i);          return ex(i, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic exp_t s_beq(logic [2:0] i, logic z); return ex(i, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0); endfunction
   function automatic exp_t s_jal(logic [2:0] i);          return ex(i, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0); endfunction
   function automatic exp_t s_lui(logic [2:0] i);          return ex(i, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 0); endfunction

   task automatic add(string nm, logic [31:0] ins, logic z, logic mr, exp_t e);
      vec_t v;
      v.name = nm; v.instr = ins; v.z = z; v.mr = mr; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic check(string nm);
      exp_t act, e;
      act = {imm_src, pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_control, illegal_instr};
      e = exp_q.pop_front();
      n_tests++;
      if (act !== e) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h (imm=%b pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b alu=%b ill=%b) expected %h",
                  nm, act, act.imm, act.pcw, act.adr, act.mw, act.irw, act.rw, act.rs,
                  act.sa, act.sb, act.alu, act.ill, e);
      end else begin
         $display("[TB] %s ok (%h)", nm, act);
      end
   endtask

   // Drive one cycle's inputs on the falling edge, compare 2 time units later.
   task automatic step(string nm, logic [31:0] ins, logic z, logic mr, exp_t e);
      @(negedge clk);
      instruction = ins;
      zero        = z;
      mem_ready   = mr;
      exp_q.push_back(e);
      #2;
      check(nm);
   endtask

   initial begin
      // lw, 5 cycles
      add("lw.F",   I_LW, 0, 1, s_f(3'b000, 1));
      add("lw.D",   I_LW, 0, 1, s_d(3'b000, 0));
      add("lw.MA",  I_LW, 0, 1, s_ma(3'b000));
      add("lw.MR",  I_LW, 0, 1, s_mr(3'b000));
      add("lw.WB",  I_LW, 0, 1, s_mwb(3'b000));
      // fetch stall, then add
      add("add.Fs", I_ADD, 0, 0, s_f(3'b000, 0));
      add("add.F",  I_ADD, 0, 1, s_f(3'b000, 1));
      add("add.D",  I_ADD, 0, 1, s_d(3'b000, 0));
      add("add.E",  I_ADD, 0, 1, s_er(3'b000, 3'b000));
      add("add.WB", I_ADD, 0, 1, s_awb(3'b000));
      add("sub.F",  I_SUB, 0, 1, s_f(3'b000, 1));
      add("sub.D",  I_SUB, 0, 1, s_d(3'b000, 0));
      add("sub.E",  I_SUB, 0, 1, s_er(3'b000, 3'b001));
      add("sub.WB", I_SUB, 0, 1, s_awb(3'b000));
      add("slt.F",  I_SLT, 0, 1, s_f(3'b000, 1));
      add("slt.D",  I_SLT, 0, 1, s_d(3'b000, 0));
      add("slt.E",  I_SLT, 0, 1, s_er(3'b000, 3'b101));
      add("slt.WB", I_SLT, 0, 1, s_awb(3'b000));
      add("or.F",   I_OR, 0, 1, s_f(3'b000, 1));
      add("or.D",   I_OR, 0, 1, s_d(3'b000, 0));
      add("or.E",   I_OR, 0, 1, s_er(3'b000, 3'b011));
      add("or.WB",  I_OR, 0, 1, s_awb(3'b000));
      add("addi.F", I_ADDI, 0, 1, s_f(3'b000, 1));
      add("addi.D", I_ADDI, 0, 1, s_d(3'b000, 0));
      add("addi.E", I_ADDI, 0, 1, s_ei(3'b000, 3'b000));
      add("addi.WB",I_ADDI, 0, 1, s_awb(3'b000));
      add("andi.F", I_ANDI, 0, 1, s_f(3'b000, 1));
      add("andi.D", I_ANDI, 0, 1, s_d(3'b000, 0));
      add("andi.E", I_ANDI, 0, 1, s_ei(3'b000, 3'b010));
      add("andi.WB",I_ANDI, 0, 1, s_awb(3'b000));
      add("lui.F",  I_LUI, 0, 1, s_f(3'b011, 1));
      add("lui.D",  I_LUI, 0, 1, s_d(3'b011, 0));
      add("lui.L",  I_LUI, 0, 1, s_lui(3'b011));
      add("lui.WB", I_LUI, 0, 1, s_awb(3'b011));
      add("jal.F",  I_JAL, 0, 1, s_f(3'b100, 1));
      add("jal.D",  I_JAL, 0, 1, s_d(3'b100, 0));
      add("jal.J",  I_JAL, 0, 1, s_jal(3'b100));
      add("jal.WB", I_JAL, 0, 1, s_awb(3'b100));
      add("beq1.F", I_BEQ, 1, 1, s_f(3'b010, 1));
      add("beq1.D", I_BEQ, 1, 1, s_d(3'b010, 0));
      add("beq1.B", I_BEQ, 1, 1, s_beq(3'b010, 1));
      add("beq0.F", I_BEQ, 0, 1, s_f(3'b010, 1));
      add("beq0.D", I_BEQ, 0, 1, s_d(3'b010, 0));
      add("beq0.B", I_BEQ, 0, 1, s_beq(3'b010, 0));
      // load with a two-cycle memory-read stall
      add("lws.F",  I_LW, 0, 1, s_f(3'b000, 1));
      add("lws.D",  I_LW, 0, 1, s_d(3'b000, 0));
      add("lws.MA", I_LW, 0, 1, s_ma(3'b000));
      add("lws.MR0",I_LW, 0, 0, s_mr(3'b000));
      add("lws.MR1",I_LW, 0, 0, s_mr(3'b000));
      add("lws.MR2",I_LW, 0, 1, s_mr(3'b000));
      add("lws.WB", I_LW, 0, 1, s_mwb(3'b000));
      // unsupported opcode: pulse in DECODE, back to FETCH
      add("bad.F",  I_BAD, 0, 1, s_f(3'b000, 1));
      add("bad.D",  I_BAD, 0, 1, s_d(3'b000, 1));
      add("bad.F2", I_BAD, 0, 0, s_f(3'b000, 0));

      // Reset state: FETCH selects, enables forced low even with mem_ready high.
      exp_q.push_back(s_f(3'b000, 0));
      @(negedge clk);
      #2;
      check("reset");
      reset     = 1'b0;
      mem_ready = 1'b0;

      for (int k = 0; k < vecs.size(); k++)
         step(vecs[k].name, vecs[k].instr, vecs[k].z, vecs[k].mr, vecs[k].e);

      // Store held in MEMWRITE for three not-ready cycles.
      step("sw.F",   I_SW, 0, 1, s_f(3'b001, 1));
      step("sw.D",   I_SW, 0, 1, s_d(3'b001, 0));
      step("sw.MA",  I_SW, 0, 1, s_ma(3'b001));
      step("sw.MW0", I_SW, 0, 0, s_mw(3'b001));
      step("sw.MW1", I_SW, 0, 0, s_mw(3'b001));
      step("sw.MW2", I_SW, 0, 0, s_mw(3'b001));
      step("sw.MW3", I_SW, 0, 1, s_mw(3'b001));
      step("sw.F2",  I_SW, 0, 0, s_f(3'b001, 0));

      // Reset mid-store: mem_write must drop and FETCH selects appear at once.
      step("swr.F",  I_SW, 0, 1, s_f(3'b001, 1));
      step("swr.D",  I_SW, 0, 1, s_d(3'b001, 0));
      step("swr.MA", I_SW, 0, 1, s_ma(3'b001));
      step("swr.MW", I_SW, 0, 0, s_mw(3'b001));
      reset = 1'b1;
      exp_q.push_back(s_f(3'b001, 0));
      #1;
      check("swr.rst");
      step("swr.held", I_SW, 0, 1, s_f(3'b001, 0));
      reset     = 1'b0;
      mem_ready = 1'b0;
      step("swr.F2", I_SW, 0, 1, s_f(3'b001, 1));
      step("swr.D2", I_SW, 0, 1, s_d(3'b001, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control unit for the multicycle RV32I core.
- Sits directly upstream of ImmExt: decodes the instruction-register contents and drives imm_src into ImmExt.
- Sequences every instruction through a Moore FSM and drives all datapath enables and mux selects.
- Stalls on a memory-ready handshake during fetch, load and store.

Parameters:
- None. All opcodes and encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  instruction-register output; opcode [6:0], funct3 [14:12], funct7b5 [30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- imm_src  out  3  to ImmExt: 000 I, 001 S, 010 B, 011 U, 100 J
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction-register and OldPC enable
- reg_write  out  1  register-file write enable
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1, 11 constant 0
- alu_src_b  out  2  ALU B select: 00 rs2, 01 imm_ext, 10 constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset: asynchronous, active-high; state goes to FETCH.
  - While reset is high, all enables (pc_write, mem_write, ir_write, reg_write) are forced to 0 and illegal_instr is 0.
  - Selects take their FETCH values.
- Decode of imm_src (combinational, from opcode):
  - lw / I-ALU → 000; sw → 001; beq → 010; lui → 011; jal → 100; otherwise 000.
- Outputs are Moore, decoded from state. Exception: pc_write = pc_update | (branch & zero).
- Unlisted outputs are 0 in each state.
- States, outputs and transitions:
  - FETCH: adr_src 0, a 00, b 10, add, result_src 10; ir_write = pc_update = mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE: a 01, b 01, add (precomputes branch target into ALUOut). Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 0010011 (I-ALU) → EXECUTEI
    - 1100011 (beq) → BEQ
    - 1101111 (jal) → JAL
    - 0110111 (lui) → LUI
    - anything else → FETCH with illegal_instr = 1 for that cycle
  - MEMADR: a 10, b 01, add. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: adr_src 1, result_src 00. Waits for mem_ready, then → MEMWB.
  - MEMWB: result_src 01, reg_write 1 → FETCH.
  - MEMWRITE: adr_src 1, mem_write 1, held until mem_ready → FETCH.
  - EXECUTER: a 10, b 00, ALU-decoded → ALUWB.
  - EXECUTEI: a 10, b 01, ALU-decoded → ALUWB.
  - ALUWB: result_src 00, reg_write 1 → FETCH.
  - BEQ: a 10, b 00, sub, result_src 00, branch 1 → FETCH.
  - JAL: a 01, b 10, add, result_src 00, pc_update 1 → ALUWB (rd = PC+4).
  - LUI: a 11, b 01, add → ALUWB.
- ALU decoding (alu_op: 00 add, 01 sub, 10 funct):
  - funct3 000 → sub if (op[5] & funct7b5), else add
  - funct3 010 → slt; 110 → or; 111 → and
  - Other funct3 → add.
- Cycle counts with mem_ready held at 1:
  - lw 5 cycles; sw 4; R-type, I-ALU, lui and jal 4; beq 3.
- Reset asserted mid-instruction returns to FETCH immediately and aborts any pending write. A pending mem_write drops asynchronously.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants
  - the state enum
  - imm_src, result_src, alu_src_a/b and alu_control encodings
  - ImmExt uses the same imm_src constants from this package.
- One sub-module, alu_decoder: combinational mapping of alu_op, funct3, funct7b5 and op[5] to alu_control.

Test Plan:
- Reset, then mem_ready = 1 with instruction 0xFFC4A303 (lw x6,-4(x9)) → states F, D, MA, MR, WB over 5 cycles.
  - imm_src 000 throughout.
  - reg_write = 1 only in cycle 5, with result_src 01.
- sw 0x0064A423 with mem_ready low for 3 cycles in MEMWRITE → mem_write held high for 4 cycles, imm_src 001, then FETCH.
- beq 0xFE420AE3:
  - With zero = 1: pc_write = 1 in BEQ, imm_src 010, alu_control 001.
  - With zero = 0: pc_write = 0.
- jal 0x7F8A60EF → imm_src 100; pc_write in JAL; reg_write in the following ALUWB; 4 cycles total.
- add 0x00628233 → alu_control 000; sub 0x40628233 → 001; addi 0xFFF00013 → 000 (funct7b5 ignored since op[5] = 0).
- Opcode 0x7F → illegal_instr pulses for 1 cycle in DECODE, then FETCH with no write enables. Reset asserted during MEMWRITE → mem_write = 0 at once and state is FETCH.
